// File: rtl/lbr_pkg.sv
// Shared encodings for the last-branch-record unit: transfer kinds, software
// request codes, read field selectors, control bits and status word layout.
package lbr_pkg;

    typedef enum logic [1:0] {
        SEL_PC4    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JAL    = 2'b10,
        SEL_JALR   = 2'b11
    } next_sel_e;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'b00,
        REQ_CTRL  = 2'b01,
        REQ_READ  = 2'b10,
        REQ_CLEAR = 2'b11
    } lbr_req_e;

    typedef enum logic [1:0] {
        FIELD_FROM   = 2'b00,
        FIELD_TO     = 2'b01,
        FIELD_TYPE   = 2'b10,
        FIELD_STATUS = 2'b11
    } read_field_e;

    localparam int CTRL_BITS       = 5;
    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_REC_BRANCH = 1;
    localparam int CTRL_REC_JAL    = 2;
    localparam int CTRL_REC_JALR   = 3;
    localparam int CTRL_FREEZE     = 4;
    localparam logic [CTRL_BITS-1:0] CTRL_RESET = 5'h0F;

    // Status word: {wrapped, frozen, count[INDEX_BITS:0], wr_ptr[INDEX_BITS-1:0]}
    function automatic int stat_count_lo(input int index_bits);
        return index_bits;
    endfunction

    function automatic int stat_frozen_bit(input int index_bits);
        return 2 * index_bits + 1;
    endfunction

    function automatic int stat_wrapped_bit(input int index_bits);
        return 2 * index_bits + 2;
    endfunction

endpackage

// File: rtl/lbr_entry_ram.sv
// Record storage: one synchronous write port, one combinational read port.
// Contents are not reset; the top level masks slots that hold no valid record.
module lbr_entry_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 26
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lbr_unit_mk2.sv
// Last-branch-record unit: snoops next-PC selection into a circular buffer of
// {from, to, type} records with per-type filters, wrap or freeze-on-full mode.
module lbr_unit_mk2
    import lbr_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDRESS_BITS = 12,
    parameter int LBR_DEPTH    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              next_PC_sel,
    input  logic [ADDRESS_BITS-1:0] PC_address,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic [1:0]              lbrReq,
    input  logic [DATA_WIDTH-1:0]   RW_address,
    input  logic [DATA_WIDTH-1:0]   ALU_result,
    output logic [DATA_WIDTH-1:0]   output_data,
    output logic                    lbr_frozen
);

    localparam int INDEX_BITS = $clog2(LBR_DEPTH);
    localparam int ENTRY_W    = 2 * ADDRESS_BITS + 2;
    localparam int COUNT_LO   = stat_count_lo(INDEX_BITS);
    localparam int FROZEN_BIT = stat_frozen_bit(INDEX_BITS);
    localparam int WRAP_BIT   = stat_wrapped_bit(INDEX_BITS);

    localparam logic [INDEX_BITS-1:0] PTR_ONE     = INDEX_BITS'(1);
    localparam logic [INDEX_BITS:0]   CNT_ONE     = (INDEX_BITS+1)'(1);
    localparam logic [INDEX_BITS:0]   CNT_FULL    = (INDEX_BITS+1)'(LBR_DEPTH);
    localparam logic [INDEX_BITS:0]   CNT_PREFULL = (INDEX_BITS+1)'(LBR_DEPTH - 1);

    logic [INDEX_BITS-1:0]   wr_ptr;
    logic [INDEX_BITS:0]     count;
    logic                    frozen;
    logic                    wrapped;
    logic [CTRL_BITS-1:0]    ctrl;

    logic [ADDRESS_BITS-1:0] sel_target;
    logic                    type_ok;
    logic                    do_record;
    logic [ENTRY_W-1:0]      wr_entry;

    logic [INDEX_BITS-1:0]   rd_age;
    logic [1:0]              rd_field;
    logic [INDEX_BITS-1:0]   rd_slot;
    logic                    rd_valid;
    logic [ENTRY_W-1:0]      rd_entry;
    logic [DATA_WIDTH-1:0]   read_value;

    // Bits of the software interface that carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{RW_address[DATA_WIDTH-1:INDEX_BITS+2], ALU_result[DATA_WIDTH-1:CTRL_BITS]};

    always_comb begin
        sel_target = '0;
        type_ok    = 1'b0;
        case (next_sel_e'(next_PC_sel))
            SEL_BRANCH: begin
                sel_target = branch_target;
                type_ok    = ctrl[CTRL_REC_BRANCH];
            end
            SEL_JAL: begin
                sel_target = JAL_target;
                type_ok    = ctrl[CTRL_REC_JAL];
            end
            SEL_JALR: begin
                sel_target = JALR_target;
                type_ok    = ctrl[CTRL_REC_JALR];
            end
            default: begin
                sel_target = '0;
                type_ok    = 1'b0;
            end
        endcase
    end

    // Clear outranks recording, so a clear request suppresses the write too.
    assign do_record = !stall && ctrl[CTRL_ENABLE] && type_ok && !frozen
                       && (lbr_req_e'(lbrReq) != REQ_CLEAR);
    assign wr_entry  = {PC_address, sel_target, next_PC_sel};

    assign rd_field = RW_address[1:0];
    assign rd_age   = RW_address[INDEX_BITS+1:2];
    assign rd_slot  = wr_ptr - PTR_ONE - rd_age;
    assign rd_valid = ({1'b0, rd_age} < count);

    lbr_entry_ram #(
        .DEPTH  (LBR_DEPTH),
        .ADDR_W (INDEX_BITS),
        .DATA_W (ENTRY_W)
    ) u_entry_ram (
        .clock (clock),
        .we    (do_record),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_slot),
        .rdata (rd_entry)
    );

    always_comb begin
        read_value = '0;
        case (read_field_e'(rd_field))
            FIELD_FROM: begin
                if (rd_valid) read_value[ADDRESS_BITS-1:0] = rd_entry[ENTRY_W-1 -: ADDRESS_BITS];
            end
            FIELD_TO: begin
                if (rd_valid) read_value[ADDRESS_BITS-1:0] = rd_entry[2 +: ADDRESS_BITS];
            end
            FIELD_TYPE: begin
                if (rd_valid) read_value[2:0] = {1'b1, rd_entry[1:0]};
            end
            default: begin
                read_value[INDEX_BITS-1:0]         = wr_ptr;
                read_value[COUNT_LO +: INDEX_BITS+1] = count;
                read_value[FROZEN_BIT]             = frozen;
                read_value[WRAP_BIT]               = wrapped;
            end
        endcase
    end

    // lbrReq is a one-cycle command: it acts at the edge it is sampled on and
    // reads return their data on output_data from the following cycle onward.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            count       <= '0;
            frozen      <= 1'b0;
            wrapped     <= 1'b0;
            ctrl        <= CTRL_RESET;
            output_data <= '0;
        end else begin
            if (lbr_req_e'(lbrReq) == REQ_CTRL) begin
                ctrl <= ALU_result[CTRL_BITS-1:0];
            end
            if (lbr_req_e'(lbrReq) == REQ_CLEAR) begin
                wr_ptr  <= '0;
                count   <= '0;
                frozen  <= 1'b0;
                wrapped <= 1'b0;
            end else if (do_record) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (count == CNT_FULL) begin
                    wrapped <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                    if (ctrl[CTRL_FREEZE] && count == CNT_PREFULL) begin
                        frozen <= 1'b1;
                    end
                end
            end
            if (lbr_req_e'(lbrReq) == REQ_READ) begin
                output_data <= read_value;
            end
        end
    end

    assign lbr_frozen = frozen;

endmodule

// File: tb/tb_lbr_unit_mk2.sv
// Self-checking bench for lbr_unit_mk2: driver tasks issue records and software
// requests, reads push expected data that the monitor pops one cycle later.
module tb_lbr_unit_mk2;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [1:0]  next_PC_sel;
    logic [11:0] PC_address;
    logic [11:0] branch_target;
    logic [11:0] JAL_target;
    logic [11:0] JALR_target;
    logic [1:0]  lbrReq;
    logic [15:0] RW_address;
    logic [15:0] ALU_result;
    logic [15:0] output_data;
    logic        lbr_frozen;

    logic [15:0] exp_q[$];
    logic        read_cap;
    int          n_cmp;
    int          n_err;

    lbr_unit_mk2 dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .next_PC_sel   (next_PC_sel),
        .PC_address    (PC_address),
        .branch_target (branch_target),
        .JAL_target    (JAL_target),
        .JALR_target   (JALR_target),
        .lbrReq        (lbrReq),
        .RW_address    (RW_address),
        .ALU_result    (ALU_result),
        .output_data   (output_data),
        .lbr_frozen    (lbr_frozen)
    );

    // Clock and read-capture tracking
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        read_cap <= !reset && (lbrReq == 2'b10);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a read captured at the last edge is compared at the falling edge.
    always @(negedge clock) begin
        if (read_cap) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 16'(exp_q.size()), 16'd1);
            end else begin
                check("read_data", output_data, exp_q.pop_front());
            end
        end
    end

    task automatic drive_idle();
        stall         = 1'b0;
        next_PC_sel   = 2'b00;
        PC_address    = 12'($urandom_range(0, 4095));
        branch_target = 12'($urandom_range(0, 4095));
        JAL_target    = 12'($urandom_range(0, 4095));
        JALR_target   = 12'($urandom_range(0, 4095));
        lbrReq        = 2'b00;
        RW_address    = 16'($urandom_range(0, 65535));
        ALU_result    = 16'($urandom_range(0, 65535));
    endtask

    task automatic cyc(input logic [1:0] sel, input logic [11:0] pc, input logic [11:0] tgt,
                       input logic [1:0] req, input logic [15:0] addr, input logic [15:0] alu,
                       input logic stl);
        next_PC_sel   = sel;
        PC_address    = pc;
        branch_target = (sel == 2'b01) ? tgt : tgt ^ 12'hFFF;
        JAL_target    = (sel == 2'b10) ? tgt : tgt ^ 12'h5A5;
        JALR_target   = (sel == 2'b11) ? tgt : tgt ^ 12'h3C3;
        lbrReq        = req;
        RW_address    = addr;
        ALU_result    = alu;
        stall         = stl;
        @(posedge clock);
        #1;
        drive_idle();
    endtask

    task automatic rec(input logic [1:0] sel, input logic [11:0] pc, input logic [11:0] tgt);
        cyc(sel, pc, tgt, 2'b00, 16'h0000, 16'h0000, 1'b0);
    endtask

    function automatic logic [15:0] rd_addr(input logic [1:0] field, input logic [2:0] age);
        logic [10:0] noise;
        noise = 11'($urandom_range(0, 2047));
        return {noise, age, field};
    endfunction

    task automatic rd(input logic [1:0] field, input logic [2:0] age, input logic [15:0] exp);
        exp_q.push_back(exp);
        cyc(2'b00, 12'h000, 12'h000, 2'b10, rd_addr(field, age), 16'h0000, 1'b0);
    endtask

    task automatic ctrl_wr(input logic [15:0] v);
        cyc(2'b00, 12'h000, 12'h000, 2'b01, 16'h0000, v, 1'b0);
    endtask

    task automatic clr();
        cyc(2'b00, 12'h000, 12'h000, 2'b11, 16'h0000, 16'h0000, 1'b0);
    endtask

    // Status layout for depth 8: [2:0] wr_ptr, [6:3] count, [7] frozen, [8] wrapped.
    function automatic logic [15:0] stat(input int wp, input int cnt, input bit fr, input bit wr);
        logic [15:0] s;
        s      = '0;
        s[2:0] = wp[2:0];
        s[6:3] = cnt[3:0];
        s[7]   = fr;
        s[8]   = wr;
        return s;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_output_data", output_data, 16'h0000);
        check("reset_frozen", 16'(lbr_frozen), 16'h0000);

        // Basic record
        rec(2'b10, 12'h010, 12'h100);
        rec(2'b11, 12'h020, 12'h0F0);
        rd(2'b00, 3'd0, 16'h0020);
        rd(2'b01, 3'd0, 16'h00F0);
        rd(2'b10, 3'd0, 16'h0007);
        rd(2'b00, 3'd1, 16'h0010);
        rd(2'b01, 3'd1, 16'h0100);
        rd(2'b10, 3'd1, 16'h0006);
        rd(2'b11, 3'd5, stat(2, 2, 1'b0, 1'b0));
        rd(2'b00, 3'd2, 16'h0000);

        // Type filter, and a ctrl write racing a record uses the old ctrl
        clr();
        ctrl_wr(16'h0009);
        rec(2'b10, 12'h050, 12'h111);
        rec(2'b01, 12'h051, 12'h222);
        rec(2'b11, 12'h055, 12'h0AA);
        rd(2'b11, 3'd0, stat(1, 1, 1'b0, 1'b0));
        rd(2'b00, 3'd0, 16'h0055);
        rd(2'b01, 3'd0, 16'h00AA);
        rd(2'b00, 3'd1, 16'h0000);
        cyc(2'b10, 12'h060, 12'h123, 2'b01, 16'h0000, 16'h000F, 1'b0);
        rd(2'b11, 3'd0, stat(1, 1, 1'b0, 1'b0));

        // Wrap mode
        clr();
        for (int i = 0; i < 10; i++) rec(2'b10, 12'(i), 12'h800 | 12'(i));
        rd(2'b11, 3'd0, stat(2, 8, 1'b0, 1'b1));
        rd(2'b00, 3'd0, 16'h0009);
        rd(2'b00, 3'd7, 16'h0002);
        rd(2'b01, 3'd7, 16'h0802);
        rd(2'b10, 3'd7, 16'h0006);

        // Freeze on full
        clr();
        ctrl_wr(16'h001F);
        for (int i = 0; i < 7; i++) rec(2'b10, 12'(i), 12'h400 | 12'(i));
        check("frozen_before_full", 16'(lbr_frozen), 16'h0000);
        rec(2'b10, 12'h007, 12'h407);
        check("frozen_at_full", 16'(lbr_frozen), 16'h0001);
        rec(2'b10, 12'h008, 12'h408);
        rd(2'b00, 3'd0, 16'h0007);
        rd(2'b11, 3'd0, stat(0, 8, 1'b1, 1'b0));
        ctrl_wr(16'h000F);
        check("frozen_sticky", 16'(lbr_frozen), 16'h0001);
        rec(2'b10, 12'h033, 12'h444);
        rd(2'b11, 3'd0, stat(0, 8, 1'b1, 1'b0));
        clr();
        check("frozen_cleared", 16'(lbr_frozen), 16'h0000);
        rd(2'b11, 3'd0, stat(0, 0, 1'b0, 1'b0));
        rd(2'b00, 3'd0, 16'h0000);

        // Stall and same-cycle collisions
        cyc(2'b10, 12'h0A0, 12'h0B0, 2'b00, 16'h0000, 16'h0000, 1'b1);
        rd(2'b11, 3'd0, stat(0, 0, 1'b0, 1'b0));
        rec(2'b10, 12'h041, 12'h042);
        exp_q.push_back(stat(1, 1, 1'b0, 1'b0));
        cyc(2'b10, 12'h044, 12'h045, 2'b10, rd_addr(2'b11, 3'd0), 16'h0000, 1'b0);
        rd(2'b11, 3'd0, stat(2, 2, 1'b0, 1'b0));
        cyc(2'b11, 12'h046, 12'h047, 2'b11, 16'h0000, 16'h0000, 1'b0);
        rd(2'b11, 3'd0, stat(0, 0, 1'b0, 1'b0));
        rec(2'b01, 12'h070, 12'h777);
        rd(2'b01, 3'd0, 16'h0777);
        rd(2'b10, 3'd0, 16'h0005);
        rec(2'b00, 12'h071, 12'h778);
        check("read_hold", output_data, 16'h0005);

        // Reset mid-operation
        for (int i = 1; i <= 5; i++) rec(2'b10, 12'(i), 12'h200 | 12'(i));
        rd(2'b00, 3'd0, 16'h0005);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_output_data", output_data, 16'h0000);
        check("midreset_frozen", 16'(lbr_frozen), 16'h0000);
        rd(2'b11, 3'd0, stat(0, 0, 1'b0, 1'b0));
        rec(2'b10, 12'h0AB, 12'h0CD);
        rd(2'b00, 3'd0, 16'h00AB);
        rd(2'b01, 3'd0, 16'h00CD);
        rd(2'b11, 3'd0, stat(1, 1, 1'b0, 1'b0));

        repeat (3) @(posedge clock);
        #1;
        check("sb_drain", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lbr_unit_mk2.md
Name: lbr_unit_mk2

Overview:
Parametrised last-branch-record unit, successor to the fixed-mode LBR.
- Snoops the core's next-PC selection and stores from/to/type records in a circular buffer.
- Per-type recording filters, selectable wrap or freeze-on-full mode, status word.
- Software read/clear/control through the lbrReq/RW_address/ALU_result access path; sits beside the fetch stage.

Parameters:
DATA_WIDTH, 16, width of RW_address, ALU_result and output_data
ADDRESS_BITS, 12, PC/target width (ADDRESS_BITS <= DATA_WIDTH)
LBR_DEPTH, 8, entries; power of 2, >= 2
INDEX_BITS, log2(LBR_DEPTH), derived; constraint DATA_WIDTH >= 2*INDEX_BITS+3

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
stall  in  1  pipeline stall; no recording while high
next_PC_sel  in  2  00 PC+4, 01 taken branch, 10 JAL, 11 JALR
PC_address  in  ADDRESS_BITS  PC of the control-transfer instruction
branch_target  in  ADDRESS_BITS  taken-branch target
JAL_target  in  ADDRESS_BITS  JAL target
JALR_target  in  ADDRESS_BITS  JALR target
lbrReq  in  2  00 idle, 01 write control, 10 read, 11 clear
RW_address  in  DATA_WIDTH  read select: [1:0] field, [INDEX_BITS+1:2] age index (0 = newest)
ALU_result  in  DATA_WIDTH  control write data
output_data  out  DATA_WIDTH  registered read data
lbr_frozen  out  1  buffer frozen (full in freeze mode)

Behaviour:
Single clock; reset is synchronous and active-high.
- Reset: wr_ptr=0, count=0, frozen=0, wrapped=0, ctrl=CTRL_RESET (0x000F), output_data=0, lbr_frozen=0.
- Entry storage contents need no reset; entries at age >= count are never returned.
- ctrl bits: [0] enable, [1] rec_branch, [2] rec_jal, [3] rec_jalr, [4] freeze_on_full; other bits read 0.
- Record condition: !stall & enable & type filter bit set for next_PC_sel (01/10/11) & !frozen & lbrReq != 11. next_PC_sel = 00 never records.
- Record action, at the clock edge:
  - entry[wr_ptr] = {from=PC_address, to=selected target, type=next_PC_sel}.
  - wr_ptr = wr_ptr+1 mod LBR_DEPTH.
  - If count == LBR_DEPTH, set wrapped (sticky); otherwise count++.
- Freeze: when freeze_on_full=1 and a record makes count == LBR_DEPTH, frozen=1 the same edge; lbr_frozen follows frozen. Later records are dropped.
- Clearing freeze_on_full does not unfreeze; only clear or reset does.
- Control write (lbrReq=01): ctrl <= ALU_result[4:0] at the edge. A record in the same cycle uses the old ctrl.
- Clear (lbrReq=11): count=0, wr_ptr=0, frozen=0, wrapped=0, ctrl unchanged. Clear wins over a simultaneous record.
- Read (lbrReq=10): output_data updates at the edge, so it is valid one cycle after the request. Holds its value when lbrReq != 10.
  - Physical slot = (wr_ptr-1-age) mod LBR_DEPTH.
  - Field 00: from, zero-extended.
  - Field 01: to, zero-extended.
  - Field 10: {valid, type[1:0]}, zero-extended.
  - Field 11 (status, age ignored): [INDEX_BITS-1:0] wr_ptr; [2*INDEX_BITS:INDEX_BITS] count; next bit frozen; next bit wrapped; upper bits 0.
  - age >= count with field 00/01/10: output_data=0.
- Read in the same cycle as a record returns the pre-record state (pointer, count and entries).
- RW_address bits above INDEX_BITS+1 are ignored.

Decomposition:
lbr_pkg holds:
- next_PC_sel encodings
- lbrReq encodings
- read field codes
- ctrl bit positions and CTRL_RESET
- status bit offset functions of INDEX_BITS

Sub-module lbr_entry_ram:
- LBR_DEPTH x (2*ADDRESS_BITS+2) array.
- One synchronous write port, one combinational read port.
- No reset.

Top level owns pointers, count, flags, ctrl, filter logic and the output register.

Test Plan:
1. Basic record: reset; JAL PC=0x010 target 0x100, then JALR PC=0x020 target 0x0F0 -> age0: from=0x020, to=0x0F0, type=0x7 (valid, 11). Age1 from=0x010. Status count=2, wr_ptr=2.
2. Filter: write ctrl=0x0009; issue JAL, branch, JALR PC=0x055 -> only the JALR is recorded, count=1, age0 from=0x055, age1 reads 0.
3. Wrap: ctrl=0x000F; 10 JALs PC=i, target 0x800|i -> count=8, wrapped=1, wr_ptr=2, age0 from=9, age7 from=2/to=0x802.
4. Freeze: ctrl=0x001F; 9 JALs PC=i -> lbr_frozen=1 after the 8th, 9th dropped, age0 from=7, wrapped=0. Clear -> count=0, lbr_frozen=0, age0 reads 0.
5. Stall and collisions:
   - Record with stall=1 -> count unchanged.
   - Record plus read of status in the same cycle -> old count returned.
   - Record plus clear in the same cycle -> count=0.
6. Reset mid-operation: 5 records, then reset for 1 cycle -> output_data=0, status=0, ctrl reads back 0x000F behaviour (JAL recorded next).
